// File: rtl/all_pkgs.sv
`default_nettype none
// =============================================================================
// Module   : all_pkgs
// Brief    : Shared widths, the HALT encoding and fetch FSM states.
// Revision : 1.0 - initial release
// =============================================================================
package all_pkgs;

  localparam int WIDTH = 32;

  // EBREAK encoding doubles as the halt marker.
  localparam logic [WIDTH-1:0] HALT = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// =============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two instruction queue with synchronous flush and count.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [DW-1:0]   r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            w_wr;
  logic            w_rd;

  assign full  = (r_count == c_cw'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= r_count + c_cw'(w_wr) - c_cw'(w_rd);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : fetch_stage
// Brief    : Single-outstanding instruction fetch with queue and redirect.
//            Optional halt-on-HALT-word behaviour under macro FETCH_HALT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_stage
  import all_pkgs::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t       r_state;
  logic [WIDTH-1:0]   r_fetch_pc;
  logic [WIDTH-1:0]   r_req_pc;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [c_cnt_w-1:0] w_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               w_room;
  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_redirect_pc;
  logic               w_halted;
  logic               w_halt_hit;

  assign imem_req      = (r_state == REQ);
  assign imem_addr     = r_fetch_pc;
  assign if_valid      = !w_empty;
  assign if_pc         = w_head[2*WIDTH-1:WIDTH];
  assign if_instr      = w_head[WIDTH-1:0];
  assign w_redirect_pc = redirect_pc & ~WIDTH'(3);

  // A response landing together with a redirect is stale and never pushed.
  assign w_push      = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop       = if_valid && id_ready;
  assign w_count_nxt = w_count + c_cnt_w'(1) - c_cnt_w'(w_pop);
  assign w_room      = (w_count_nxt < c_cnt_w'(FIFO_DEPTH));

`ifdef FETCH_HALT_EN
  logic r_halted;

  assign w_halt_hit = w_push && (imem_rdata == HALT);
  assign w_halted   = r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_halt_hit) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign w_halt_hit = 1'b0;
  assign w_halted   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      if (redirect_valid) r_fetch_pc <= w_redirect_pc;
      case (r_state)
        IDLE: begin
          if (redirect_valid || (!w_full && !w_halted)) r_state <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            r_req_pc <= r_fetch_pc;
            if (redirect_valid) begin
              r_state <= DROP;
            end else begin
              r_state    <= WAIT;
              r_fetch_pc <= r_fetch_pc + WIDTH'(4);
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            r_state <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            r_state <= (w_room && !w_halt_hit) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) r_state <= REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (2 * WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata ({r_req_pc, imem_rdata}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed bench for fetch_stage with a latency-configurable memory.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fetch_stage;
  import all_pkgs::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             if_valid;
  logic             id_ready;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_instr;

  int               lat;
  logic             halt_inject;
  logic             pend;
  int               cnt;
  logic [WIDTH-1:0] paddr;

  int               n_pass  = 0;
  int               n_total = 0;
  logic             found;
  int               n_pops;
  logic [WIDTH-1:0] pop_pc [8];
  logic [WIDTH-1:0] pop_in [8];

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  // Word i lives at byte address 4i; optionally address 8 holds HALT.
  function automatic logic [WIDTH-1:0] word_at(input logic [WIDTH-1:0] a, input logic inj);
    if (inj && a == 32'h8) return HALT;
    return a >> 2;
  endfunction

  assign imem_gnt = imem_req;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      pend        <= 1'b0;
      cnt         <= 0;
      paddr       <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend && cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= word_at(paddr, halt_inject);
        pend        <= 1'b0;
      end else if (pend) begin
        cnt <= cnt - 1;
      end
      if (imem_req && imem_gnt) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= word_at(imem_addr, halt_inject);
        end else begin
          pend  <= 1'b1;
          paddr <= imem_addr;
          cnt   <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req_gnt(input string tag);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 1;
    halt_inject    = 1'b0;
    n_pops         = 0;
    repeat (3) step();

    chk("rst_req",    32'(imem_req), 32'd0);
    chk("rst_valid",  32'(if_valid), 32'd0);
    chk("rst_pc",     if_pc,         32'h0);
    chk("rst_instr",  if_instr,      32'h0);
    chk("rst_addr",   imem_addr,     32'h0);

    // Reset release, zero-wait memory, decode stalled.
    rst_n = 1'b1;
    step();
    chk("first_req",  32'(imem_req), 32'd1);
    chk("first_addr", imem_addr,     32'h0);
    step();
    chk("wait_noreq", 32'(imem_req), 32'd0);
    chk("wait_novld", 32'(if_valid), 32'd0);
    step();
    chk("lat2_valid", 32'(if_valid), 32'd1);
    chk("lat2_pc",    if_pc,         32'h0);
    chk("lat2_instr", if_instr,      32'h0);
    chk("second_req", 32'(imem_req), 32'd1);
    chk("second_addr", imem_addr,    32'h4);

    repeat (6) step();
    chk("full_noreq9", 32'(imem_req), 32'd0);
    step();
    chk("full_noreq10", 32'(imem_req), 32'd0);
    chk("full_head",    if_pc,         32'h0);
    chk("full_fpc",     imem_addr,     32'h10);

    // Drain while fetching resumes.
    id_ready = 1'b1;
    step();
    chk("drain_pc4",   if_pc,         32'h4);
    chk("drain_idle",  32'(imem_req), 32'd0);
    step();
    chk("drain_pc8",   if_pc,         32'h8);
    chk("resume_req",  32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr,     32'h10);
    step();
    chk("drain_pc12",  if_pc,         32'hC);
    step();
    chk("pc16",        if_pc,         32'h10);
    chk("instr16",     if_instr,      32'h4);
    chk("addr20",      imem_addr,     32'h14);
    step();
    chk("empty_again", 32'(if_valid), 32'd0);

    // Redirect while WAIT has no response yet.
    lat = 2;
    wait_req_gnt("rd1_gnt");
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("drop_novld",  32'(if_valid), 32'd0);
    chk("drop_noreq",  32'(imem_req), 32'd0);
    step();
    chk("rd1_req",     32'(imem_req), 32'd1);
    chk("rd1_addr",    imem_addr,     32'h100);
    chk("rd1_novld",   32'(if_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("rd1_vld_seen", 32'(found), 32'd1);
    chk("rd1_pc",       if_pc,      32'h100);
    chk("rd1_instr",    if_instr,   32'h40);

    // Redirect coincident with rvalid and a pop.
    id_ready = 1'b0;
    lat      = 1;
    wait_req_gnt("rd2_gnt");
    step();
    chk("rd2_pre_vld", 32'(if_valid), 32'd1);
    chk("rd2_pre_pc",  if_pc,         32'h100);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    chk("rd2_flushed", 32'(if_valid), 32'd0);
    chk("rd2_req",     32'(imem_req), 32'd1);
    chk("rd2_addr",    imem_addr,     32'h200);
    step();
    chk("rd2_novld",   32'(if_valid), 32'd0);
    step();
    chk("rd2_vld",     32'(if_valid), 32'd1);
    chk("rd2_pc",      if_pc,         32'h200);
    chk("rd2_instr",   if_instr,      32'h80);

    // Reset asserted mid-WAIT.
    lat = 2;
    wait_req_gnt("rst_gnt");
    step();
    rst_n       = 1'b0;
    halt_inject = 1'b1;
    #1;
    chk("mid_rst_req",   32'(imem_req), 32'd0);
    chk("mid_rst_vld",   32'(if_valid), 32'd0);
    chk("mid_rst_pc",    if_pc,         32'h0);
    chk("mid_rst_instr", if_instr,      32'h0);
    chk("mid_rst_addr",  imem_addr,     32'h0);
    step();
    rst_n    = 1'b1;
    lat      = 1;
    id_ready = 1'b1;
    step();
    chk("post_rst_req",  32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr,     32'h0);

    // HALT word at address 8.
    for (int i = 0; i < 16; i++) begin
      if (if_valid && id_ready && n_pops < 8) begin
        pop_pc[n_pops] = if_pc;
        pop_in[n_pops] = if_instr;
        n_pops++;
      end
      step();
    end
    chk("halt_pop0",  n_pops > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h0);
    chk("halt_pop1",  n_pops > 1 ? pop_pc[1] : 32'hDEAD_BEEF, 32'h4);
    chk("halt_pop2",  n_pops > 2 ? pop_pc[2] : 32'hDEAD_BEEF, 32'h8);
    chk("halt_word",  n_pops > 2 ? pop_in[2] : 32'hDEAD_BEEF, HALT);
`ifdef FETCH_HALT_EN
    chk("halt_npops", 32'(n_pops),   32'd3);
    chk("halt_noreq", 32'(imem_req), 32'd0);
    chk("halt_fpc",   imem_addr,     32'hC);
`else
    chk("nohalt_more", 32'(n_pops > 3), 32'd1);
`endif

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr == 32'h40) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("resume_40", 32'(found), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the instruction queue depth (power of two, 2..16).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  out  1  SHALL mark a valid instruction-memory request.
REQ-006 imem_addr  out  WIDTH  SHALL carry the request byte address.
REQ-007 imem_gnt  in  1  SHALL accept the request in the cycle it is high together with imem_req.
REQ-008 imem_rvalid  in  1  SHALL mark valid response data, no earlier than 1 cycle after the grant.
REQ-009 imem_rdata  in  WIDTH  SHALL carry the response instruction word.
REQ-010 redirect_valid  in  1  SHALL request a pipeline redirect from execute (jump or taken branch).
REQ-011 redirect_pc  in  WIDTH  SHALL carry the redirect target.
REQ-012 if_valid  out  1  SHALL indicate that if_pc and if_instr hold a valid queue head.
REQ-013 id_ready  in  1  SHALL indicate that decode accepts the head this cycle.
REQ-014 if_pc, if_instr  out  WIDTH each  SHALL carry the head's PC and instruction word.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, REQ, WAIT and DROP, allowing at most one outstanding memory request.
REQ-016 imem_req SHALL be high only in REQ, with imem_addr equal to fetch_pc.
REQ-017 Transitions SHALL be: IDLE->REQ when the queue has a free slot and the block is not halted; REQ->WAIT on imem_gnt, with fetch_pc += 4; WAIT->REQ on imem_rvalid if a slot remains after the push, otherwise WAIT->IDLE.
REQ-018 On imem_rvalid in WAIT, the block SHALL push {request PC, imem_rdata} into the queue.
REQ-019 Pushed data SHALL become visible on if_* in the following cycle; the minimum latency from request to if_valid SHALL be 2 cycles when the grant is zero-wait and the response arrives 1 cycle later.
REQ-020 A pop SHALL occur when if_valid && id_ready; a simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-021 No request SHALL be issued while occupancy equals FIFO_DEPTH; a pop in the same cycle frees a slot for the next cycle.
REQ-022 On redirect_valid, the block SHALL flush the queue, set fetch_pc to {redirect_pc[WIDTH-1:2], 2'b00} and clear halted; if_valid SHALL be 0 in the next cycle.
REQ-023 A redirect in IDLE SHALL go to REQ.
REQ-024 A redirect in REQ without grant SHALL stay in REQ, with imem_addr switching to the new PC in the next cycle.
REQ-025 A redirect in REQ with grant SHALL go to DROP.
REQ-026 A redirect in WAIT without rvalid SHALL go to DROP.
REQ-027 A redirect in WAIT with rvalid SHALL discard the data and go to REQ.
REQ-028 A redirect in DROP SHALL stay in DROP, updating fetch_pc only.
REQ-029 In DROP, imem_rvalid SHALL discard the data and move the FSM to REQ.
REQ-030 A pop in the same cycle as a redirect SHALL count as consumed; the redirect still flushes all remaining entries.
REQ-031 fetch_pc SHALL wrap modulo 2^WIDTH.

Reset
REQ-032 While rst_n is low: state IDLE, fetch_pc = RESET_PC, queue empty, halted = 0, imem_req = 0, if_valid = 0, if_pc = 0, if_instr = 0, imem_addr = RESET_PC.
REQ-033 A reset mid-transaction SHALL abandon the outstanding request; the memory model is reset with the same rst_n.

Configuration
REQ-034 With macro FETCH_HALT_EN defined, pushing a word equal to HALT SHALL set halted; no further requests SHALL be issued until a redirect occurs, and queued entries SHALL still drain.
REQ-035 Without FETCH_HALT_EN, HALT words SHALL be treated as ordinary instructions and the halted logic SHALL be absent.

Structure
REQ-036 WIDTH, HALT and typedef enum fetch_state_t {IDLE, REQ, WAIT, DROP} SHALL live in all_pkgs.
REQ-037 The queue SHALL be the sub-module fetch_fifo, parameterised by depth and entry width 2*WIDTH, exposing push, pop, flush, full, empty and count.

Verification
REQ-038 Reset release, zero-wait memory returning word i at address 4i -> requests at 0, 4, 8, ...; first if_valid 2 cycles after the first request, with if_pc=0.
REQ-039 id_ready held 0 with FIFO_DEPTH=4 -> exactly 4 entries queued, imem_req stays 0; raising id_ready drains PCs 0, 4, 8, 12 in order, and fetching resumes at 16.
REQ-040 Redirect to 0x100 while in WAIT -> the stale response is dropped, the next request is at 0x100, and no stale entry appears on if_*.
REQ-041 Redirect to 0x203 in the same cycle as imem_rvalid and a pop -> the popped entry is consumed, the response is discarded, the queue is empty, and the next imem_addr is 0x200.
REQ-042 FETCH_HALT_EN defined, HALT at 0x8 -> no request beyond 0x8; entries 0, 4, 8 drain; a redirect to 0x40 resumes fetching at 0x40.
REQ-043 rst_n asserted while in WAIT -> all outputs take their reset values immediately; after release, the first request is at RESET_PC.
